fetch_stage: RTL and testbench

Instruction-fetch stage of the single-issue processor. Holds the program counter, issues one-at-a-time read requests to instruction memory over a req/ack handshake, and presents each fetched 32-bit instruction with its PC and 5-bit opcode to the decode/control stage through a one-entry valid/ready output buffer. Accepts PC redirects, for branch and jump, that flush buffered and in-flight instructions.

---
 rtl/fetch_stage_pkg.sv | 13 +
 rtl/fetch_stage.sv | 85 ++++++++
 tb/tb_fetch_stage.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: ISA opcode constants, opcode field bounds and fetch FSM states
package fetch_stage_pkg;
    localparam logic [4:0] OPC_R    = 5'b00000;
    localparam logic [4:0] OPC_ADDI = 5'b00101;
    localparam logic [4:0] OPC_SW   = 5'b00111;
    localparam logic [4:0] OPC_LW   = 5'b01000;
    localparam int OPC_HI = 31;
    localparam int OPC_LO = 27;
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, STALL} fetch_state_t;
    function automatic logic [4:0] opcode_of(input logic [31:0] w);
        return w[OPC_HI:OPC_LO];
    endfunction
endpackage

// File: rtl/fetch_stage.sv
// fetch_stage: PC, single-outstanding imem req/ack fetch and one-entry valid/ready insn buffer
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              insn_valid,
    output logic [31:0]       insn,
    output logic [ADDR_W-1:0] insn_pc,
    output logic [4:0]        insn_opcode,
    input  logic              insn_ready
);
    fetch_state_t state, state_n;
    logic [ADDR_W-1:0] pc, pc_n, held;
    logic valid_n, load;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            held       <= '0;
            insn_valid <= 1'b0;
            insn       <= '0;
            insn_pc    <= '0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            insn_valid <= valid_n;
            if (state == FETCH) held <= pc;
            if (load) begin
                insn    <= imem_rdata;
                insn_pc <= pc;
            end
        end
    end

    // a redirect always wins over a same-cycle ack or transfer
    always_comb begin
        state_n = state;
        pc_n    = pc;
        valid_n = insn_valid;
        load    = 1'b0;
        case (state)
            IDLE: state_n = FETCH;
            FETCH: begin
                if (redirect_valid) begin
                    pc_n    = redirect_pc;
                    state_n = imem_ack ? FETCH : DRAIN;
                end else if (imem_ack) begin
                    load    = 1'b1;
                    valid_n = 1'b1;
                    pc_n    = pc + ADDR_W'(1);
                    state_n = STALL;
                end
            end
            DRAIN: begin
                if (redirect_valid) pc_n = redirect_pc;
                if (imem_ack) state_n = FETCH;
            end
            default: begin
                if (redirect_valid) begin
                    valid_n = 1'b0;
                    pc_n    = redirect_pc;
                    state_n = FETCH;
                end else if (insn_valid && insn_ready) begin
                    valid_n = 1'b0;
                    state_n = FETCH;
                end
            end
        endcase
    end

    assign imem_req    = (state == FETCH) || (state == DRAIN);
    assign imem_addr   = (state == DRAIN) ? held : pc;
    assign insn_opcode = opcode_of(insn);
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized imem/redirect/back-pressure stimulus checked against a transaction-level model
module tb_fetch_stage;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_req, imem_ack = 1'b0;
    logic [11:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [11:0] redirect_pc = '0;
    logic        insn_valid, insn_ready = 1'b0;
    logic [31:0] insn;
    logic [11:0] insn_pc;
    logic [4:0]  insn_opcode;

    logic        w_rst_n = 1'b0, w_req, w_ack = 1'b0, w_valid;
    logic [11:0] w_addr, w_ipc;
    logic [31:0] w_rdata = '0, w_insn;
    logic [4:0]  w_opc;
    logic [11:0] w_q[$];

    int tests = 0, fails = 0;
    logic [31:0] mem[4096];
    bit m_valid, m_stale, p_req, p_ack;
    logic [31:0] m_insn;
    logic [11:0] m_pc, m_next, p_addr;
    int wcnt = 0, lat = 2;

    always #5 clock = ~clock;

    fetch_stage #(.ADDR_W(12), .RESET_PC(12'h000)) dut (
        .clock(clock), .reset_n(reset_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .insn_valid(insn_valid), .insn(insn), .insn_pc(insn_pc),
        .insn_opcode(insn_opcode), .insn_ready(insn_ready)
    );

    fetch_stage #(.ADDR_W(12), .RESET_PC(12'hFFF)) dut_w (
        .clock(clock), .reset_n(w_rst_n), .imem_req(w_req), .imem_addr(w_addr),
        .imem_ack(w_ack), .imem_rdata(w_rdata), .redirect_valid(1'b0),
        .redirect_pc(12'h000), .insn_valid(w_valid), .insn(w_insn), .insn_pc(w_ipc),
        .insn_opcode(w_opc), .insn_ready(1'b1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_stale = 0; m_next = 12'h000; m_insn = '0; m_pc = '0;
        p_req = 0; p_ack = 0; p_addr = '0; wcnt = 0;
    endtask

    task automatic check_outputs();
        chk("insn_valid", insn_valid, m_valid);
        if (m_valid) begin
            chk("insn", insn, m_insn);
            chk("insn_pc", insn_pc, m_pc);
            chk("insn_opcode", insn_opcode, m_insn[31:27]);
            chk("req_while_full", imem_req, 0);
        end
        if (p_req && !p_ack) chk("req_hold", imem_req, 1);
        if (imem_req) begin
            if (!p_req || p_ack) chk("req_addr", imem_addr, m_next);
            else chk("addr_hold", imem_addr, p_addr);
        end
    endtask

    task automatic step(input bit rd, input logic [11:0] rpc, input bit rdy);
        bit ack;
        @(negedge clock);
        insn_ready = rdy;
        if (!reset_n) begin
            imem_ack = 0; redirect_valid = 0;
            model_reset();
        end else begin
            check_outputs();
            if (imem_req) begin
                ack = (wcnt >= lat);
                wcnt = ack ? 0 : wcnt + 1;
            end else begin
                ack = 0;
                wcnt = 0;
            end
            imem_ack = ack;
            imem_rdata = ack ? mem[imem_addr] : $urandom;
            redirect_valid = rd && (imem_req || insn_valid);
            redirect_pc = rpc;
            if (m_valid && insn_ready && !redirect_valid) m_valid = 0;
            if (imem_req && imem_ack) begin
                if (!m_stale && !redirect_valid) begin
                    m_valid = 1; m_insn = mem[imem_addr]; m_pc = imem_addr; m_next = imem_addr + 12'd1;
                end
                m_stale = 0;
            end else if (imem_req && redirect_valid) m_stale = 1;
            if (redirect_valid) begin
                m_next = redirect_pc;
                m_valid = 0;
            end
            p_req = imem_req; p_ack = imem_req && imem_ack; p_addr = imem_addr;
        end
    endtask

    task automatic wait_valid(input bit rdy);
        for (int i = 0; i < 40 && !insn_valid; i++) step(0, 12'h0, rdy);
        chk("wait_valid", insn_valid, 1);
    endtask

    task automatic wait_req(input bit rdy);
        for (int i = 0; i < 40 && !imem_req; i++) step(0, 12'h0, rdy);
        chk("wait_req", imem_req, 1);
    endtask

    initial begin
        w_rst_n = 1'b0;
        repeat (3) @(negedge clock);
        w_rst_n = 1'b1;
        forever begin
            @(negedge clock);
            w_ack = w_req;
            w_rdata = {20'h0, w_addr};
            if (w_req && w_q.size() < 8) w_q.push_back(w_addr);
        end
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = $urandom;
        mem[0] = 32'h2800_0000;
        model_reset();
        repeat (3) step(0, 12'h0, 0);
        chk("rst_insn_valid", insn_valid, 0);
        chk("rst_insn", insn, 0);
        chk("rst_insn_pc", insn_pc, 0);
        chk("rst_req", imem_req, 0);
        reset_n = 1'b1;
        // reset and first fetch, ack two cycles after req
        lat = 2;
        wait_req(0);
        chk("first_addr", imem_addr, 12'h000);
        wait_valid(0);
        chk("first_opcode", insn_opcode, 5'b00101);
        chk("first_pc", insn_pc, 12'h000);
        chk("first_insn", insn, 32'h2800_0000);
        // back-pressure
        repeat (10) step(0, 12'h0, 0);
        chk("bp_insn", insn, 32'h2800_0000);
        chk("bp_req", imem_req, 0);
        step(0, 12'h0, 1);
        step(0, 12'h0, 0);
        chk("after_bp_req", imem_req, 1);
        chk("after_bp_addr", imem_addr, 12'h001);
        // redirect while waiting for ack
        step(1, 12'h100, 0);
        step(0, 12'h0, 0);
        chk("drain_hold_addr", imem_addr, 12'h001);
        wait_valid(0);
        chk("redir_pc", insn_pc, 12'h100);
        // redirect with buffer full and decode ready
        step(1, 12'h020, 1);
        step(0, 12'h0, 1);
        chk("flush_valid", insn_valid, 0);
        chk("flush_req", imem_req, 1);
        chk("flush_addr", imem_addr, 12'h020);
        wait_valid(0);
        chk("flush_next_pc", insn_pc, 12'h020);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [11:0] rpc;
            if (wcnt == 0) lat = $urandom_range(0, 3);
            rpc = ($urandom_range(0, 3) == 0) ? 12'hFFE + 12'($urandom_range(0, 1)) : 12'($urandom_range(0, 4095));
            step($urandom_range(0, 14) == 0, rpc, $urandom_range(0, 2) != 0);
        end
        // async reset while draining
        lat = 3;
        for (int i = 0; i < 40 && !(imem_req && wcnt == 1); i++) step(0, 12'h0, 1);
        chk("pre_drain_req", imem_req, 1);
        step(1, 12'h3A0, 1);
        step(0, 12'h0, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_req", imem_req, 0);
        chk("async_valid", insn_valid, 0);
        chk("async_insn", insn, 0);
        chk("async_pc", insn_pc, 0);
        imem_ack = 0;
        model_reset();
        repeat (2) step(0, 12'h0, 0);
        reset_n = 1'b1;
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        wait_req(0);
        chk("restart_addr", imem_addr, 12'h000);
        wait_valid(0);
        chk("restart_pc", insn_pc, 12'h000);
        chk("restart_insn", insn, 32'h2800_0000);
        // PC wrap on the RESET_PC=0xFFF instance
        chk("wrap_count", 32'(w_q.size() >= 2), 1);
        if (w_q.size() >= 2) begin
            chk("wrap_first", w_q[0], 12'hFFF);
            chk("wrap_second", w_q[1], 12'h000);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
